// File: rtl/ysyx_22050710_sram_arbiter_pkg.sv
// Purpose : shared types and default sizes for the SRAM-port arbiter.
// Contents: bus width defaults, outstanding-depth default, owner id enum
//           (which master a request or response belongs to).
package ysyx_22050710_sram_arbiter_pkg;

    localparam int SRAM_ADDR_WD   = 32;
    localparam int SRAM_DATA_WD   = 64;
    localparam int SRAM_WMASK_WD  = 8;
    localparam int OUTS_DEPTH_DEF = 2;

    typedef enum logic {
        OWNER_INST = 1'b0,
        OWNER_DATA = 1'b1
    } owner_e;

endpackage

// File: rtl/ysyx_22050710_sram_arbiter_if.sv
// Purpose : one SRAM-like port (req/addr_ok/data_ok handshake).
// Modports: master - drives req/op/size/addr/wstrb/wdata, receives addr_ok/data_ok/rdata
//           slave  - the reverse side
interface ysyx_22050710_sram_arbiter_if
    import ysyx_22050710_sram_arbiter_pkg::*;
#(
    parameter int AW = SRAM_ADDR_WD,
    parameter int DW = SRAM_DATA_WD,
    parameter int MW = SRAM_WMASK_WD
);
    logic          req;
    logic          op;
    logic [1:0]    size;
    logic [AW-1:0] addr;
    logic [MW-1:0] wstrb;
    logic [DW-1:0] wdata;
    logic          addr_ok;
    logic          data_ok;
    logic [DW-1:0] rdata;

    modport master (
        output req, op, size, addr, wstrb, wdata,
        input  addr_ok, data_ok, rdata
    );

    modport slave (
        input  req, op, size, addr, wstrb, wdata,
        output addr_ok, data_ok, rdata
    );
endinterface

// File: rtl/ysyx_22050710_owner_fifo.sv
// Purpose : records which master owns each accepted, not yet answered request.
//           1 bit wide, DEPTH deep, in-order.
// Ports   : i_clk, i_rst (async, active-high)
//           i_push/i_din  - enqueue owner id (ignored when full)
//           i_pop         - dequeue head (ignored when empty, so no bypass)
//           o_full/o_empty/o_head - status and current head
module ysyx_22050710_owner_fifo #(
    parameter int DEPTH = 2
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_push,
    input  logic i_din,
    input  logic i_pop,
    output logic o_full,
    output logic o_empty,
    output logic o_head
);
    localparam int            PW       = $clog2(DEPTH);
    localparam logic [PW:0]   FULL_CNT = (PW+1)'(DEPTH);

    logic [DEPTH-1:0] r_mem;
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [PW:0]      r_cnt;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_cnt == FULL_CNT);
    assign o_empty   = (r_cnt == '0);
    assign o_head    = r_mem[r_rd_ptr];
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    // Pointers are log2(DEPTH) bits and wrap naturally (DEPTH is a power of 2).
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_mem    <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= i_din;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end
endmodule

// File: rtl/ysyx_22050710_sram_arbiter.sv
// Purpose : shares one SRAM-like slave port between the inst master (m0_if)
//           and the data master (m1_if). Fixed priority m1 > m0; a grant that
//           has been presented but not yet accepted is locked until addr_ok.
//           In-order responses are routed back through an owner FIFO.
// Ports   : i_clk, i_rst (async, active-high)
//           m0_if, m1_if - master-facing ports (slave modport)
//           s_if         - memory-facing port (master modport)
//           o_resp_err   - sticky: data_ok arrived with nothing outstanding
module ysyx_22050710_sram_arbiter
    import ysyx_22050710_sram_arbiter_pkg::*;
#(
    parameter int OUTS_DEPTH = OUTS_DEPTH_DEF
) (
    input  logic                           i_clk,
    input  logic                           i_rst,
    ysyx_22050710_sram_arbiter_if.slave    m0_if,
    ysyx_22050710_sram_arbiter_if.slave    m1_if,
    ysyx_22050710_sram_arbiter_if.master   s_if,
    output logic                           o_resp_err
);
    logic   r_lock;
    owner_e r_lock_id;
    logic   r_resp_err;

    owner_e w_owner;
    logic   w_gnt_req;
    logic   w_s_req;
    logic   w_push;
    logic   w_pop;
    logic   w_resp_drop;
    logic   w_fifo_full;
    logic   w_fifo_empty;
    logic   w_fifo_head;
    logic   w_sel_m1;

    always_comb begin
        w_owner   = OWNER_INST;
        w_gnt_req = 1'b0;
        if (r_lock) begin
            w_owner   = r_lock_id;
            w_gnt_req = (r_lock_id == OWNER_DATA) ? m1_if.req : m0_if.req;
        end else if (m1_if.req) begin
            w_owner   = OWNER_DATA;
            w_gnt_req = 1'b1;
        end else if (m0_if.req) begin
            w_owner   = OWNER_INST;
            w_gnt_req = 1'b1;
        end
    end

    // A full FIFO blocks the request even if a response pops it this cycle.
    assign w_sel_m1    = (w_owner == OWNER_DATA);
    assign w_s_req     = !i_rst && w_gnt_req && !w_fifo_full;
    assign w_push      = w_s_req && s_if.addr_ok;
    assign w_pop       = !i_rst && s_if.data_ok && !w_fifo_empty;
    assign w_resp_drop = !i_rst && s_if.data_ok && w_fifo_empty;

    assign s_if.req   = w_s_req;
    assign s_if.op    = w_sel_m1 ? m1_if.op    : m0_if.op;
    assign s_if.size  = w_sel_m1 ? m1_if.size  : m0_if.size;
    assign s_if.addr  = w_sel_m1 ? m1_if.addr  : m0_if.addr;
    assign s_if.wstrb = w_sel_m1 ? m1_if.wstrb : m0_if.wstrb;
    assign s_if.wdata = w_sel_m1 ? m1_if.wdata : m0_if.wdata;

    assign m0_if.addr_ok = w_push && !w_sel_m1;
    assign m1_if.addr_ok = w_push &&  w_sel_m1;
    assign m0_if.data_ok = w_pop && (w_fifo_head == OWNER_INST);
    assign m1_if.data_ok = w_pop && (w_fifo_head == OWNER_DATA);
    assign m0_if.rdata   = s_if.rdata;
    assign m1_if.rdata   = s_if.rdata;
    assign o_resp_err    = r_resp_err;

    ysyx_22050710_owner_fifo #(
        .DEPTH (OUTS_DEPTH)
    ) u_owner_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (w_push),
        .i_din   (w_sel_m1),
        .i_pop   (w_pop),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_head  (w_fifo_head)
    );

    // Hold the owner of a presented-but-unaccepted request so a later m1
    // request cannot swap the fields under the slave.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_lock    <= 1'b0;
            r_lock_id <= OWNER_INST;
        end else if (w_s_req && !s_if.addr_ok) begin
            r_lock    <= 1'b1;
            r_lock_id <= w_owner;
        end else if (s_if.addr_ok) begin
            r_lock    <= 1'b0;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_resp_err <= 1'b0;
        end else if (w_resp_drop) begin
            r_resp_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_ysyx_22050710_sram_arbiter.sv
module tb_ysyx_22050710_sram_arbiter;

    localparam logic [31:0] M0_ADDR  = 32'h8000_0000;
    localparam logic [31:0] M1_ADDR  = 32'h8000_1000;
    localparam logic [63:0] M0_WDATA = 64'h0;
    localparam logic [63:0] M1_WDATA = 64'hDEAD_BEEF_0123_4567;

    logic clk = 1'b0;
    logic rst;
    logic resp_err;

    always #5 clk = ~clk;

    ysyx_22050710_sram_arbiter_if if_m0 ();
    ysyx_22050710_sram_arbiter_if if_m1 ();
    ysyx_22050710_sram_arbiter_if if_s  ();

    ysyx_22050710_sram_arbiter dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .m0_if      (if_m0),
        .m1_if      (if_m1),
        .s_if       (if_s),
        .o_resp_err (resp_err)
    );

    // in = {rst, m0_req, m1_req, s_addr_ok, s_data_ok}
    // ex = {s_req, m0_addr_ok, m1_addr_ok, owner of s fields (1 = m1)}
    // data_ok expectations come from the owner scoreboard, not the table.
    typedef struct {
        logic [4:0]  in;
        logic [63:0] rdata;
        logic [3:0]  ex;
    } vec_t;

    vec_t tbl [29];
    logic sb [$];
    logic err_m;
    int   n_vec;
    int   n_fail;

    function automatic vec_t mk(input logic [4:0] i, input logic [63:0] r, input logic [3:0] e);
        vec_t v;
        v.in    = i;
        v.rdata = r;
        v.ex    = e;
        return v;
    endfunction

    task automatic chk1(input string name, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %b expected %b", name, $time, act, exp);
        end
    endtask

    task automatic chk64(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic apply(input vec_t v);
        logic r, m0, m1, aok, dok;
        logic es, ea0, ea1, eo;
        logic ed0, ed1, eerr;
        {r, m0, m1, aok, dok} = v.in;
        {es, ea0, ea1, eo}    = v.ex;
        @(negedge clk);
        rst           = r;
        if_m0.req     = m0;
        if_m1.req     = m1;
        if_s.addr_ok  = aok;
        if_s.data_ok  = dok;
        if_s.rdata    = v.rdata;
        ed0 = 1'b0;
        ed1 = 1'b0;
        if (!r && dok && sb.size() > 0) begin
            if (sb[0]) ed1 = 1'b1;
            else       ed0 = 1'b1;
        end
        eerr = r ? 1'b0 : err_m;
        #1;
        chk1("s_req",      if_s.req,      es);
        chk1("m0_addr_ok", if_m0.addr_ok, ea0);
        chk1("m1_addr_ok", if_m1.addr_ok, ea1);
        chk1("m0_data_ok", if_m0.data_ok, ed0);
        chk1("m1_data_ok", if_m1.data_ok, ed1);
        chk1("resp_err",   resp_err,      eerr);
        if (es) begin
            chk64("s_addr",  64'(if_s.addr), 64'(eo ? M1_ADDR : M0_ADDR));
            chk1 ("s_op",    if_s.op,        eo);
            chk64("s_wdata", if_s.wdata,     eo ? M1_WDATA : M0_WDATA);
        end
        if (ed0) chk64("m0_rdata", if_m0.rdata, v.rdata);
        if (ed1) chk64("m1_rdata", if_m1.rdata, v.rdata);
        @(posedge clk);
        if (r) begin
            sb.delete();
            err_m = 1'b0;
        end else begin
            if (dok) begin
                if (sb.size() > 0) void'(sb.pop_front());
                else               err_m = 1'b1;
            end
            if (ea0) sb.push_back(1'b0);
            if (ea1) sb.push_back(1'b1);
        end
    endtask

    initial begin
        logic        ow;
        logic [63:0] rd;
        n_vec  = 0;
        n_fail = 0;
        err_m  = 1'b0;
        rst    = 1'b1;
        if_m0.req = 1'b0; if_m0.op = 1'b0; if_m0.size = 2'd2;
        if_m0.addr = M0_ADDR; if_m0.wstrb = 8'h00; if_m0.wdata = M0_WDATA;
        if_m1.req = 1'b0; if_m1.op = 1'b1; if_m1.size = 2'd3;
        if_m1.addr = M1_ADDR; if_m1.wstrb = 8'hF0; if_m1.wdata = M1_WDATA;
        if_s.addr_ok = 1'b0; if_s.data_ok = 1'b0; if_s.rdata = 64'h0;

        // reset with everything asserted
        tbl[0]  = mk(5'b11111, 64'h0,  4'b0000);
        tbl[1]  = mk(5'b00000, 64'h0,  4'b0000);
        // both request: m1 first, then m0; drain in order
        tbl[2]  = mk(5'b01110, 64'h0,  4'b1011);
        tbl[3]  = mk(5'b01010, 64'h0,  4'b1100);
        tbl[4]  = mk(5'b00001, 64'hA1, 4'b0000);
        tbl[5]  = mk(5'b00001, 64'hA5, 4'b0000);
        // m0 held without addr_ok, m1 arrives: m0 keeps the port
        tbl[6]  = mk(5'b01000, 64'h0,  4'b1000);
        tbl[7]  = mk(5'b01100, 64'h0,  4'b1000);
        tbl[8]  = mk(5'b01100, 64'h0,  4'b1000);
        tbl[9]  = mk(5'b01110, 64'h0,  4'b1100);
        tbl[10] = mk(5'b00110, 64'h0,  4'b1011);
        tbl[11] = mk(5'b00001, 64'h11, 4'b0000);
        tbl[12] = mk(5'b00001, 64'h22, 4'b0000);
        // fill to depth, full blocks even on a pop cycle
        tbl[13] = mk(5'b00110, 64'h0,  4'b1011);
        tbl[14] = mk(5'b01010, 64'h0,  4'b1100);
        tbl[15] = mk(5'b01010, 64'h0,  4'b0000);
        tbl[16] = mk(5'b01011, 64'h33, 4'b0000);
        tbl[17] = mk(5'b01010, 64'h0,  4'b1100);
        // push+pop on a non-full FIFO
        tbl[18] = mk(5'b00001, 64'h44, 4'b0000);
        tbl[19] = mk(5'b00111, 64'h55, 4'b1011);
        tbl[20] = mk(5'b00001, 64'h66, 4'b0000);
        // push+pop on an empty FIFO: response dropped, error sticks
        tbl[21] = mk(5'b01011, 64'h77, 4'b1100);
        tbl[22] = mk(5'b00001, 64'h88, 4'b0000);
        tbl[23] = mk(5'b00001, 64'h99, 4'b0000);
        // outstanding + lock, then reset mid-transaction
        tbl[24] = mk(5'b01010, 64'h0,  4'b1100);
        tbl[25] = mk(5'b01000, 64'h0,  4'b1000);
        tbl[26] = mk(5'b11100, 64'h0,  4'b0000);
        tbl[27] = mk(5'b00110, 64'h0,  4'b1011);
        tbl[28] = mk(5'b00001, 64'hAB, 4'b0000);

        for (int i = 0; i < 29; i++) apply(tbl[i]);

        // random single-master transactions with random read data
        for (int k = 0; k < 6; k++) begin
            ow = 1'($urandom_range(0, 1));
            rd = {$urandom, $urandom};
            apply(mk(ow ? 5'b00110 : 5'b01010, 64'h0, ow ? 4'b1011 : 4'b1100));
            apply(mk(5'b00001, rd, 4'b0000));
        end

        // two back-to-back accepts then two back-to-back responses
        apply(mk(5'b01010, 64'h0, 4'b1100));
        apply(mk(5'b00110, 64'h0, 4'b1011));
        apply(mk(5'b00001, 64'h1234_5678_9ABC_DEF0, 4'b0000));
        apply(mk(5'b00001, 64'h0FED_CBA9_8765_4321, 4'b0000));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
